// File: rtl/main_scu_bac_initiator.sv
// BAC register-bus initiator: turns single read/write commands into one BAC access
// each, with a ready timeout, and returns exactly one response per command.
module main_scu_bac_initiator #(
    parameter int unsigned p_bac_reg_offset_address_width = 12,
    parameter int unsigned p_response_width               = 3,
    parameter int unsigned p_timeout_cycles               = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      cmd_valid_i,
    output logic                                      cmd_ready_o,
    input  logic                                      cmd_wr_i,
    input  logic [p_bac_reg_offset_address_width-1:0] cmd_addr_i,
    input  logic [31:0]                               cmd_wdata_i,
    input  logic [3:0]                                cmd_byte_en_i,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic                                      rsp_wr_o,
    output logic [31:0]                               rsp_rdata_o,
    output logic [p_response_width-1:0]               rsp_status_o,
    output logic                                      bac_csb_o,
    output logic                                      bac_wr_o,
    output logic [p_bac_reg_offset_address_width-1:0] bac_address_o,
    output logic [31:0]                               bac_write_data_o,
    output logic [3:0]                                bac_byte_en_o,
    input  logic [31:0]                               bac_read_data_i,
    input  logic                                      bac_ready_i,
    input  logic [p_response_width-1:0]               bac_response_i,
    output logic                                      busy_o
);

    localparam int unsigned TW = $clog2(p_timeout_cycles) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(p_timeout_cycles - 1);
    localparam logic [31:0] ABORT_RDATA = 32'hdead_0bac;

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

    state_t                                state_q, state_d;
    logic [TW-1:0]                         tmo_q, tmo_d;
    logic                                  csb_d, wr_d;
    logic [p_bac_reg_offset_address_width-1:0] addr_d;
    logic [31:0]                           wdata_d;
    logic [3:0]                            be_d;
    logic                                  rsp_valid_d, rsp_wr_d;
    logic [31:0]                           rsp_rdata_d;
    logic [p_response_width-1:0]           rsp_status_d;

    assign cmd_ready_o = (state_q == IDLE) && !rst_i;
    assign busy_o      = (state_q != IDLE);

    // NOTE: every signal assigned here gets a hold default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        csb_d        = bac_csb_o;
        wr_d         = bac_wr_o;
        addr_d       = bac_address_o;
        wdata_d      = bac_write_data_o;
        be_d         = bac_byte_en_o;
        rsp_valid_d  = rsp_valid_o;
        rsp_wr_d     = rsp_wr_o;
        rsp_rdata_d  = rsp_rdata_o;
        rsp_status_d = rsp_status_o;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d  = ACCESS;
                    tmo_d    = '0;
                    csb_d    = 1'b0;
                    wr_d     = cmd_wr_i;
                    addr_d   = cmd_addr_i;
                    wdata_d  = cmd_wr_i ? cmd_wdata_i : 32'h0;
                    be_d     = cmd_byte_en_i;
                    rsp_wr_d = cmd_wr_i;
                end
            end
            ACCESS: begin
                if (bac_ready_i) begin
                    csb_d = 1'b1;
                    if (bac_wr_o) begin
                        rsp_status_d = bac_response_i;
                        rsp_rdata_d  = 32'h0;
                        state_d      = RESP;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Last permitted select cycle without ready: abort the access.
                    csb_d        = 1'b1;
                    rsp_status_d = '1;
                    rsp_rdata_d  = ABORT_RDATA;
                    state_d      = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RDATA: begin
                rsp_rdata_d  = bac_read_data_i;
                rsp_status_d = bac_response_i;
                state_d      = RESP;
            end
            RESP: begin
                if (!rsp_valid_o) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            tmo_q            <= '0;
            bac_csb_o        <= 1'b1;
            bac_wr_o         <= 1'b0;
            bac_address_o    <= '0;
            bac_write_data_o <= 32'h0;
            bac_byte_en_o    <= 4'h0;
            rsp_valid_o      <= 1'b0;
            rsp_wr_o         <= 1'b0;
            rsp_rdata_o      <= 32'h0;
            rsp_status_o     <= '0;
        end else begin
            state_q          <= state_d;
            tmo_q            <= tmo_d;
            bac_csb_o        <= csb_d;
            bac_wr_o         <= wr_d;
            bac_address_o    <= addr_d;
            bac_write_data_o <= wdata_d;
            bac_byte_en_o    <= be_d;
            rsp_valid_o      <= rsp_valid_d;
            rsp_wr_o         <= rsp_wr_d;
            rsp_rdata_o      <= rsp_rdata_d;
            rsp_status_o     <= rsp_status_d;
        end
    end

endmodule

// File: tb/tb_main_scu_bac_initiator.sv
// Self-checking bench: directed vector table, randomized transactions against a
// behavioural model, and hand-written reset/back-pressure sequences.
module tb_main_scu_bac_initiator;

    localparam int AW  = 12;
    localparam int RW  = 3;
    localparam int TMO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [AW-1:0] cmd_addr_i;
    logic [31:0]   cmd_wdata_i;
    logic [3:0]    cmd_byte_en_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_wr_o;
    logic [31:0]   rsp_rdata_o;
    logic [RW-1:0] rsp_status_o;
    logic          bac_csb_o, bac_wr_o;
    logic [AW-1:0] bac_address_o;
    logic [31:0]   bac_write_data_o;
    logic [3:0]    bac_byte_en_o;
    logic [31:0]   bac_read_data_i;
    logic          bac_ready_i;
    logic [RW-1:0] bac_response_i;
    logic          busy_o;

    main_scu_bac_initiator #(
        .p_bac_reg_offset_address_width(AW),
        .p_response_width(RW),
        .p_timeout_cycles(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_byte_en_i(cmd_byte_en_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_status_o(rsp_status_o),
        .bac_csb_o(bac_csb_o), .bac_wr_o(bac_wr_o), .bac_address_o(bac_address_o),
        .bac_write_data_o(bac_write_data_o), .bac_byte_en_o(bac_byte_en_o),
        .bac_read_data_i(bac_read_data_i), .bac_ready_i(bac_ready_i),
        .bac_response_i(bac_response_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dly;         // select cycles with ready low before ready rises
        logic [31:0] tgt_rdata;
        logic [RW-1:0] tgt_resp;
        int          stall;       // cycles rsp_ready_i is held low
        logic [RW-1:0] exp_status;
        logic [31:0] exp_rdata;
        int          exp_lat;     // accept edge to first rsp_valid_o
        int          exp_csb;     // cycles with bac_csb_o low
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(bit wr, logic [AW-1:0] addr, logic [31:0] wdata, logic [3:0] be,
                                int dly, logic [31:0] rdata, logic [RW-1:0] resp, int stall,
                                logic [RW-1:0] es, logic [31:0] erd, int elat, int ecsb);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.dly = dly;
        v.tgt_rdata = rdata; v.tgt_resp = resp; v.stall = stall;
        v.exp_status = es; v.exp_rdata = erd; v.exp_lat = elat; v.exp_csb = ecsb;
        return v;
    endfunction

    // Reference model: outcome of one command derived from the protocol rules alone.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        bit timeout = (v.dly >= TMO);
        r.exp_csb    = timeout ? TMO : v.dly + 1;
        r.exp_status = timeout ? '1 : v.tgt_resp;
        r.exp_rdata  = timeout ? 32'hdead_0bac : (v.wr ? 32'h0 : v.tgt_rdata);
        r.exp_lat    = r.exp_csb + ((v.wr || timeout) ? 1 : 2);
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   wait_cyc = 0;
        int   lat = 0, csb_low = 0, accesses = 0;
        bit   stable_ok = 1'b1, prev_rd_access = 1'b0, ok_hold = 1'b1;
        logic ready_now;
        logic [31:0] h_rdata;
        logic [RW-1:0] h_status;

        cmd_valid_i = 1'b1; cmd_wr_i = v.wr; cmd_addr_i = v.addr;
        cmd_wdata_i = v.wdata; cmd_byte_en_i = v.be;
        while (!cmd_ready_o && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        if (!cmd_ready_o) begin
            check({tag, " accept_timeout"}, 32'(cmd_ready_o), 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        step();
        cmd_valid_i = 1'b0;
        cmd_wr_i = ~v.wr; cmd_addr_i = AW'($urandom);
        cmd_wdata_i = $urandom; cmd_byte_en_i = 4'($urandom);

        while (!rsp_valid_o && lat < 200) begin
            if (!bac_csb_o) begin
                csb_low++;
                if (bac_wr_o !== v.wr || bac_address_o !== v.addr || bac_byte_en_o !== v.be ||
                    bac_write_data_o !== (v.wr ? v.wdata : 32'h0))
                    stable_ok = 1'b0;
                ready_now = (csb_low - 1 == v.dly);
                if (ready_now) accesses++;
                bac_ready_i     = ready_now;
                bac_response_i  = (ready_now && v.wr) ? v.tgt_resp : ~v.tgt_resp;
                bac_read_data_i = ~v.tgt_rdata;
                prev_rd_access  = ready_now && !v.wr;
            end else begin
                bac_ready_i     = 1'($urandom);
                bac_response_i  = prev_rd_access ? v.tgt_resp : ~v.tgt_resp;
                bac_read_data_i = prev_rd_access ? v.tgt_rdata : ~v.tgt_rdata;
                prev_rd_access  = 1'b0;
            end
            step();
            lat++;
        end
        bac_ready_i = 1'b0;
        check({tag, " rsp_valid_seen"}, 32'(rsp_valid_o), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " csb_low_cycles"}, 32'(csb_low), 32'(v.exp_csb));
        check({tag, " access_count"}, 32'(accesses), (v.dly >= TMO) ? 32'd0 : 32'd1);
        check({tag, " bac_stable"}, 32'(stable_ok), 32'd1);
        check({tag, " status"}, 32'(rsp_status_o), 32'(v.exp_status));
        check({tag, " rdata"}, rsp_rdata_o, v.exp_rdata);
        check({tag, " rsp_wr"}, 32'(rsp_wr_o), 32'(v.wr));
        check({tag, " busy"}, 32'(busy_o), 32'd1);

        // Back-pressure with a competing command waiting at the input.
        h_rdata = rsp_rdata_o; h_status = rsp_status_o;
        rsp_ready_i = 1'b0;
        cmd_valid_i = (v.stall > 0);
        for (int i = 0; i < v.stall; i++) begin
            step();
            if (!rsp_valid_o || rsp_rdata_o !== h_rdata || rsp_status_o !== h_status ||
                rsp_wr_o !== v.wr || cmd_ready_o || !bac_csb_o)
                ok_hold = 1'b0;
        end
        if (v.stall > 0) check({tag, " rsp_hold"}, 32'(ok_hold), 32'd1);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        check({tag, " rsp_valid_drop"}, 32'(rsp_valid_o), 32'd0);
        check({tag, " idle_after"}, 32'(busy_o), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        bit stale;

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_byte_en_i = '0; rsp_ready_i = 1'b0;
        bac_read_data_i = '0; bac_ready_i = 1'b0; bac_response_i = '0;

        vecs[0] = mk(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 0,   32'h0,         3'd0, 0, 3'd0, 32'h0,         2,  1);
        vecs[1] = mk(1'b0, 12'h010, 32'h0,         4'h3, 0,   32'h0000_1234, 3'd0, 0, 3'd0, 32'h0000_1234, 3,  1);
        vecs[2] = mk(1'b0, 12'h024, 32'h0,         4'hC, 3,   32'h1357_9bdf, 3'd2, 0, 3'd2, 32'h1357_9bdf, 6,  4);
        vecs[3] = mk(1'b0, 12'h100, 32'h0,         4'hF, 255, 32'h1111_2222, 3'd1, 0, 3'd7, 32'hdead_0bac, 17, 16);
        vecs[4] = mk(1'b1, 12'hFFC, 32'h0BAD_F00D, 4'h0, 1,   32'h0,         3'd5, 5, 3'd5, 32'h0,         3,  2);
        vecs[5] = mk(1'b0, 12'h3A8, 32'h0,         4'h1, 15,  32'hCAFE_0001, 3'd3, 2, 3'd3, 32'hCAFE_0001, 18, 16);
        vecs[6] = mk(1'b1, 12'h004, 32'h5555_AAAA, 4'h6, 300, 32'h0,         3'd0, 1, 3'd7, 32'hdead_0bac, 17, 16);

        repeat (3) step();
        check("reset cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("reset csb", 32'(bac_csb_o), 32'd1);
        check("reset bac_outs", {bac_address_o, 3'b0, bac_wr_o, bac_byte_en_o, 12'h0}, 32'h0);
        check("reset wdata", bac_write_data_o, 32'h0);
        check("reset rsp", {28'h0, rsp_valid_o, rsp_status_o}, 32'h0);
        check("reset rsp_data", {rsp_rdata_o[31:1], rsp_wr_o}, 32'h0);
        check("reset busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("post-reset cmd_ready", 32'(cmd_ready_o), 32'd1);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int   r = $urandom_range(0, 9);
            v.wr = 1'($urandom); v.addr = AW'($urandom); v.wdata = $urandom;
            v.be = 4'($urandom); v.tgt_rdata = $urandom; v.tgt_resp = RW'($urandom);
            v.dly = (r == 9) ? TMO + int'($urandom_range(0, 3)) : r;
            v.stall = $urandom_range(0, 3);
            run_txn(model(v), $sformatf("rand%0d", i));
        end

        // Reset while a read is waiting for ready: no response may ever appear.
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 12'h020; cmd_byte_en_i = 4'hF;
        bac_ready_i = 1'b0;
        check("midrst cmd_ready", 32'(cmd_ready_o), 32'd1);
        step();
        cmd_valid_i = 1'b0;
        step(); step();
        check("midrst csb_low", 32'(bac_csb_o), 32'd0);
        rst_i = 1'b1;
        step();
        check("midrst csb", 32'(bac_csb_o), 32'd1);
        check("midrst rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst cmd_ready_in_rst", 32'(cmd_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("midrst cmd_ready_after", 32'(cmd_ready_o), 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bac_ready_i = 1'($urandom); rsp_ready_i = 1'($urandom);
            step();
            if (rsp_valid_o || !bac_csb_o || busy_o) stale = 1'b1;
        end
        rsp_ready_i = 1'b0; bac_ready_i = 1'b0;
        check("midrst no_stale", 32'(stale), 32'd0);
        run_txn(model(mk(1'b0, 12'h020, 32'h0, 4'hF, 0, 32'h600D_0001, 3'd0, 0, 3'd0, 32'h0, 0, 0)),
                "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
